rtc_cnt_ctrl: RTL and testbench

//  Sequencer for the RTC 32-bit counter datapath, in the rtc_clk domain.
//  - Prescaler generates the counter's single-cycle increment strobe (cnt_en).
//  - req/ack FSM turns software load requests into the counter's one-cycle load pulse.
//  - Match detector raises a sticky, maskable interrupt.

---
 rtl/rtc_pkg.sv | 14 +
 rtl/rtc_cnt_ctrl_if.sv | 23 ++
 rtl/rtc_presc.sv | 33 +++
 rtl/rtc_cnt_ctrl.sv | 101 ++++++++++
 tb/tb_rtc_cnt_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_pkg.sv
// RTC control shared types and default widths.
// Holds the load FSM state encoding and datapath widths.
package rtc_pkg;

  localparam int PRESC_W = 16;
  localparam int CNT_W   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACK  = 2'd2
  } state_t;

endpackage

// File: rtl/rtc_cnt_ctrl_if.sv
// 4-phase load handshake between register bank and RTC sequencer.
// master drives load_req/load_val; slave returns load_ack.
interface rtc_cnt_ctrl_if #(
  parameter int CNT_W = rtc_pkg::CNT_W
);

  logic             load_req;
  logic [CNT_W-1:0] load_val;
  logic             load_ack;

  modport master (
    output load_req,
    output load_val,
    input  load_ack
  );

  modport slave (
    input  load_req,
    input  load_val,
    output load_ack
  );

endinterface

// File: rtl/rtc_presc.sv
// RTC prescaler: emits a registered one-cycle tick every prescale+1 cycles.
// Ports: clk, rst_n, run, clr, prescale in; tick out.
module rtc_presc #(
  parameter int W = rtc_pkg::PRESC_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  input  logic         clr,
  input  logic [W-1:0] prescale,
  output logic         tick
);

  logic [W-1:0] pre_cnt;

  // >= so a prescale lowered below pre_cnt fires on the next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else if (!run || clr) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else if (pre_cnt >= prescale) begin
      pre_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/rtc_cnt_ctrl.sv
// RTC counter sequencer: prescaler strobe, load handshake, match irq.
// Ports: rtc_clk/presetn, ctrl/match/irq levels, ld handshake, rtc_cnt controls.
module rtc_cnt_ctrl #(
  parameter int PRESC_W = rtc_pkg::PRESC_W,
  parameter int CNT_W   = rtc_pkg::CNT_W
) (
  input  logic               rtc_clk,
  input  logic               presetn,
  input  logic               ctrl_en,
  input  logic               wrap_in,
  input  logic [PRESC_W-1:0] prescale,
  rtc_cnt_ctrl_if.slave      ld,
  input  logic [CNT_W-1:0]   match_val,
  input  logic [CNT_W-1:0]   count_val,
  input  logic               int_en,
  input  logic               int_clr,
  output logic               cnt_en,
  output logic               wrap_en,
  output logic               pdu_aou_wen_clr_sync,
  output logic [CNT_W-1:0]   pdu_aou_clr_reg,
  output logic               rtc_status,
  output logic               rtc_irq,
  output logic               busy
);

  import rtc_pkg::*;

  state_t state_q;
  state_t state_d;
  logic   tick;
  logic   idle;
  logic   match_hit;

  assign idle = (state_q == IDLE);

  rtc_presc #(
    .W (PRESC_W)
  ) u_presc (
    .clk      (rtc_clk),
    .rst_n    (presetn),
    .run      (ctrl_en),
    .clr      (!idle),
    .prescale (prescale),
    .tick     (tick)
  );

  // a tick registered on the IDLE->LOAD edge must not reach rtc_cnt
  assign cnt_en    = tick & idle;
  assign match_hit = cnt_en & (count_val == match_val);
  assign rtc_irq   = rtc_status & int_en;

  always_ff @(posedge rtc_clk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    ld.load_ack          = 1'b0;
    pdu_aou_wen_clr_sync = 1'b0;
    busy                 = 1'b1;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (ld.load_req) state_d = LOAD;
      end
      LOAD: begin
        pdu_aou_wen_clr_sync = 1'b1;
        state_d              = ACK;
      end
      ACK: begin
        ld.load_ack = 1'b1;
        if (!ld.load_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rtc_clk or negedge presetn) begin
    if (!presetn) begin
      pdu_aou_clr_reg <= '0;
      wrap_en         <= 1'b0;
      rtc_status      <= 1'b0;
    end else begin
      wrap_en <= wrap_in;
      if (idle && ld.load_req) begin
        pdu_aou_clr_reg <= ld.load_val;
      end
      // set beats a same-cycle clear
      if (match_hit) begin
        rtc_status <= 1'b1;
      end else if (int_clr) begin
        rtc_status <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rtc_cnt_ctrl.sv
// Directed bench for rtc_cnt_ctrl with a behavioural rtc_cnt model.
// Expected values queue up as stimulus is driven and are popped on check.
module tb_rtc_cnt_ctrl;

  logic        clk = 1'b0;
  logic        presetn;
  logic        ctrl_en;
  logic        wrap_in;
  logic [15:0] prescale;
  logic [31:0] match_val;
  logic [31:0] count_val;
  logic        int_en;
  logic        int_clr;
  logic        cnt_en;
  logic        wrap_en;
  logic        wen;
  logic [31:0] clr_reg;
  logic        rtc_status;
  logic        rtc_irq;
  logic        busy;
  logic        cnt_set;
  logic [31:0] cnt_set_val;

  int nvec = 0;
  int nerr = 0;
  logic [31:0] exp_q[$];

  rtc_cnt_ctrl_if ld_if ();

  rtc_cnt_ctrl dut (
    .rtc_clk              (clk),
    .presetn              (presetn),
    .ctrl_en              (ctrl_en),
    .wrap_in              (wrap_in),
    .prescale             (prescale),
    .ld                   (ld_if.slave),
    .match_val            (match_val),
    .count_val            (count_val),
    .int_en               (int_en),
    .int_clr              (int_clr),
    .cnt_en               (cnt_en),
    .wrap_en              (wrap_en),
    .pdu_aou_wen_clr_sync (wen),
    .pdu_aou_clr_reg      (clr_reg),
    .rtc_status           (rtc_status),
    .rtc_irq              (rtc_irq),
    .busy                 (busy)
  );

  always #5 clk = ~clk;

  // rtc_cnt stand-in
  always @(posedge clk) begin
    if (cnt_set) count_val <= cnt_set_val;
    else if (wen) count_val <= clr_reg;
    else if (cnt_en) count_val <= count_val + 32'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic want(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    nvec++;
    if (exp_q.size() == 0) begin
      nerr++;
      $error("FAIL %s: observed %h, no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        nerr++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic set_cnt(input logic [31:0] v);
    cnt_set = 1'b1;
    cnt_set_val = v;
    tick();
    cnt_set = 1'b0;
  endtask

  initial begin
    presetn = 1'b0;
    ctrl_en = 1'b0;
    wrap_in = 1'b0;
    prescale = '0;
    match_val = 32'hFFFF_0000;
    int_en = 1'b0;
    int_clr = 1'b0;
    cnt_set = 1'b0;
    cnt_set_val = '0;
    count_val = '0;
    ld_if.load_req = 1'b0;
    ld_if.load_val = '0;

    // reset state
    #12;
    want(0); chk("rst_cnt_en", 32'(cnt_en));
    want(0); chk("rst_ack", 32'(ld_if.load_ack));
    want(0); chk("rst_wen", 32'(wen));
    want(0); chk("rst_clr_reg", clr_reg);
    want(0); chk("rst_status", 32'(rtc_status));
    want(0); chk("rst_busy", 32'(busy));
    presetn = 1'b1;
    tick();

    wrap_in = 1'b1;
    want(1);
    tick();
    chk("wrap_en", 32'(wrap_en));

    // 1: prescale=3 -> strobe every 4th cycle
    prescale = 16'd3;
    ctrl_en = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      want(32'(n % 4 == 0));
      tick();
      chk("t1_cnt_en", 32'(cnt_en));
    end
    ctrl_en = 1'b0;
    tick();
    tick();

    // 2: match on 7 with prescale=0
    match_val = 32'd7;
    int_en = 1'b1;
    prescale = 16'd0;
    set_cnt(32'd5);
    ctrl_en = 1'b1;
    tick();
    want(1); chk("t2_cnt_en", 32'(cnt_en));
    tick();
    tick();
    want(7); chk("t2_count", count_val);
    want(0); chk("t2_status_pre", 32'(rtc_status));
    want(1);
    want(1);
    tick();
    chk("t2_status", 32'(rtc_status));
    chk("t2_irq", 32'(rtc_irq));
    int_clr = 1'b1;
    want(0);
    want(0);
    tick();
    int_clr = 1'b0;
    ctrl_en = 1'b0;
    chk("t2_status_clr", 32'(rtc_status));
    chk("t2_irq_clr", 32'(rtc_irq));
    tick();
    tick();

    // 4: set wins over same-cycle clear; mask
    set_cnt(32'd6);
    ctrl_en = 1'b1;
    tick();
    tick();
    int_clr = 1'b1;
    int_en = 1'b0;
    want(1);
    want(0);
    tick();
    int_clr = 1'b0;
    chk("t4_status", 32'(rtc_status));
    chk("t4_irq_masked", 32'(rtc_irq));
    int_en = 1'b1;
    want(1);
    #1;
    chk("t4_irq_unmask", 32'(rtc_irq));
    ctrl_en = 1'b0;
    int_clr = 1'b1;
    want(0);
    tick();
    int_clr = 1'b0;
    chk("t4_status_clr", 32'(rtc_status));
    tick();
    tick();

    // 5: prescale lowered 100 -> 2 at pre_cnt=50
    prescale = 16'd100;
    ctrl_en = 1'b1;
    for (int n = 1; n <= 50; n++) begin
      want(0);
      tick();
      chk("t5_cnt_en_slow", 32'(cnt_en));
    end
    prescale = 16'd2;
    for (int n = 51; n <= 60; n++) begin
      want(32'((n - 51) % 3 == 0));
      tick();
      chk("t5_cnt_en_fast", 32'(cnt_en));
    end
    ctrl_en = 1'b0;
    tick();
    tick();

    // 3: load handshake while counting every cycle
    match_val = 32'h1234_5678;
    prescale = 16'd0;
    ctrl_en = 1'b1;
    tick();
    want(1); chk("t3_cnt_en_pre", 32'(cnt_en));
    ld_if.load_val = 32'h1234_5678;
    ld_if.load_req = 1'b1;
    tick();
    ld_if.load_val = 32'hDEAD_BEEF;
    want(1); chk("t3_wen", 32'(wen));
    want(32'h1234_5678); chk("t3_clr_reg", clr_reg);
    want(1); chk("t3_busy", 32'(busy));
    want(0); chk("t3_cnt_en_load", 32'(cnt_en));
    want(0); chk("t3_ack_load", 32'(ld_if.load_ack));
    for (int n = 0; n < 3; n++) begin
      tick();
      want(0); chk("t3_wen_ack", 32'(wen));
      want(1); chk("t3_ack", 32'(ld_if.load_ack));
      want(0); chk("t3_cnt_en_ack", 32'(cnt_en));
      want(32'h1234_5678); chk("t3_clr_hold", clr_reg);
    end
    want(32'h1234_5678); chk("t3_count_loaded", count_val);
    want(0); chk("t3_status_load", 32'(rtc_status));
    ld_if.load_req = 1'b0;
    tick();
    want(0); chk("t3_ack_drop", 32'(ld_if.load_ack));
    want(0); chk("t3_busy_drop", 32'(busy));
    want(0); chk("t3_cnt_en_ret", 32'(cnt_en));
    tick();
    want(1); chk("t3_cnt_en_resume", 32'(cnt_en));
    want(0); chk("t3_status_pre", 32'(rtc_status));
    tick();
    want(1); chk("t3_status_tick", 32'(rtc_status));

    // 6: reset during ACK, then fresh handshake
    ld_if.load_val = 32'hA5A5_0001;
    ld_if.load_req = 1'b1;
    tick();
    tick();
    want(1); chk("t6_ack", 32'(ld_if.load_ack));
    presetn = 1'b0;
    #1;
    want(0); chk("t6_rst_ack", 32'(ld_if.load_ack));
    want(0); chk("t6_rst_busy", 32'(busy));
    want(0); chk("t6_rst_cnt_en", 32'(cnt_en));
    want(0); chk("t6_rst_status", 32'(rtc_status));
    want(0); chk("t6_rst_clr_reg", clr_reg);
    ld_if.load_req = 1'b0;
    ctrl_en = 1'b0;
    #2;
    presetn = 1'b1;
    tick();
    want(0); chk("t6_idle", 32'(busy));
    ld_if.load_val = 32'h0BAD_F00D;
    ld_if.load_req = 1'b1;
    tick();
    want(1); chk("t6_wen", 32'(wen));
    want(32'h0BAD_F00D); chk("t6_clr_reg", clr_reg);
    tick();
    want(0); chk("t6_wen_off", 32'(wen));
    want(1); chk("t6_ack2", 32'(ld_if.load_ack));
    ld_if.load_req = 1'b0;
    tick();
    want(0); chk("t6_ack_drop", 32'(ld_if.load_ack));
    want(0); chk("t6_busy_drop", 32'(busy));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
